// File: rtl/logic_seq_pkg.sv
// Shared types and opcode constants for the bit-serial logic sequencer.
// Optional zero-flag output is controlled by LOGSEQ_ZERO_FLAG_EN (see logic_seq_ctrl).
package logic_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;

  // Opcodes 4..7 have no defined cell function.
  function automatic logic is_reserved_op(input logic [2:0] op);
    return (op > OP_NOT);
  endfunction

endpackage

// File: rtl/logic_seq_ctrl_if.sv
// Request/response handshake bundle between the ALU control path and logic_seq_ctrl.
// rsp_zero exists only when LOGSEQ_ZERO_FLAG_EN is defined.
interface logic_seq_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;
`ifdef LOGSEQ_ZERO_FLAG_EN
  logic             rsp_zero;
`endif

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy
`ifdef LOGSEQ_ZERO_FLAG_EN
    , input rsp_zero
`endif
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy
`ifdef LOGSEQ_ZERO_FLAG_EN
    , output rsp_zero
`endif
  );

endinterface

// File: rtl/logic_bit_cell.sv
// Single-bit combinational logic cell; reserved opcodes produce 0.
module logic_bit_cell
  import logic_seq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       y
);

  // Opcode decode of the one-bit function.
  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_seq_ctrl.sv
// Bit-serial sequencer: runs one logic_bit_cell across a WIDTH-bit operand pair, LSB first.
// Define LOGSEQ_ZERO_FLAG_EN to add the rsp_zero output.
module logic_seq_ctrl
  import logic_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_seq_ctrl_if.slave  bus
);

  localparam int             IW       = $clog2(WIDTH);
  localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH - 1);
  localparam logic [IW-1:0]  IDX_ONE  = IW'(1'b1);

  seq_state_e       r_state;
  seq_state_e       w_next;
  logic             r_req_ready;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [IW-1:0]    r_idx;
  logic             r_err;
  logic             w_y;
  logic             w_accept;
  logic             w_last;
  logic             w_req_rsvd;
`ifdef LOGSEQ_ZERO_FLAG_EN
  logic             r_nz;
  logic             r_zero;
`endif

  // req_ready is registered so it stays low for one IDLE cycle after a DONE exit.
  assign w_accept   = (r_state == IDLE) && r_req_ready && bus.req_valid;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_req_rsvd = is_reserved_op(bus.req_op);

  logic_bit_cell u_cell (
    .a  (r_a[r_idx]),
    .b  (r_b[r_idx]),
    .op (r_op),
    .y  (w_y)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_rsvd) begin
            w_next = DONE;
          end else begin
            w_next = RUN;
          end
        end else begin
          w_next = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = RUN;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          w_next = IDLE;
        end else begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, bit index and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_op        <= 3'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_idx       <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_op        <= bus.req_op;
            r_a         <= bus.req_a;
            r_b         <= bus.req_b;
            r_result    <= '0;
            r_idx       <= '0;
            r_err       <= w_req_rsvd;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        RUN: begin
          r_result[r_idx] <= w_y;
          if (!w_last) begin
            r_idx <= r_idx + IDX_ONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            r_err <= 1'b0;
          end
        end
        default: begin
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef LOGSEQ_ZERO_FLAG_EN
  // Zero flag built as a sticky OR of bits written during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nz   <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_nz   <= 1'b0;
            r_zero <= w_req_rsvd;
          end
        end
        RUN: begin
          r_nz <= r_nz | w_y;
          if (w_last) begin
            r_zero <= ~(r_nz | w_y);
          end
        end
        default: begin
          r_nz <= r_nz;
        end
      endcase
    end
  end

  assign bus.rsp_zero = r_zero;
`endif

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.rsp_data  = r_result;
  assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_logic_seq_ctrl.sv
// Self-checking bench for logic_seq_ctrl: directed cases plus randomized traffic against a word-level model.
module tb_logic_seq_ctrl;
  import logic_seq_pkg::*;

  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  logic_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Word-level model: response timing derived from cycle counts, data from whole-word ops.
  logic             m_ready  = 1'b1;
  logic             m_valid  = 1'b0;
  logic             m_active = 1'b0;
  int               m_wait   = 0;
  logic [WIDTH-1:0] m_data   = '0;
  logic             m_err    = 1'b0;
  logic             m_zero   = 1'b0;

  function automatic logic [WIDTH-1:0] word_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~a;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready  <= 1'b1;
      m_valid  <= 1'b0;
      m_active <= 1'b0;
      m_wait   <= 0;
      m_data   <= '0;
      m_err    <= 1'b0;
      m_zero   <= 1'b0;
    end else if (m_valid) begin
      if (bus.rsp_ready) begin
        m_valid  <= 1'b0;
        m_active <= 1'b0;
        m_err    <= 1'b0;
      end
    end else if (m_active) begin
      if (m_wait == 1) m_valid <= 1'b1;
      m_wait <= m_wait - 1;
    end else if (m_ready && bus.req_valid) begin
      m_ready  <= 1'b0;
      m_active <= 1'b1;
      if (bus.req_op > 3'd3) begin
        m_valid <= 1'b1;
        m_err   <= 1'b1;
        m_data  <= '0;
        m_zero  <= 1'b1;
      end else begin
        m_wait  <= WIDTH;
        m_err   <= 1'b0;
        m_data  <= word_op(bus.req_op, bus.req_a, bus.req_b);
        m_zero  <= (word_op(bus.req_op, bus.req_a, bus.req_b) == '0);
      end
    end else begin
      m_ready <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, just after each rising edge.
  always @(posedge clk) begin
    #1;
    chk("cyc_req_ready", {31'd0, bus.req_ready}, {31'd0, m_ready});
    chk("cyc_rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_valid});
    chk("cyc_busy",      {31'd0, bus.busy},      {31'd0, m_active});
    if (m_valid) begin
      chk("cyc_rsp_data", 32'(bus.rsp_data), 32'(m_data));
      chk("cyc_rsp_err",  {31'd0, bus.rsp_err}, {31'd0, m_err});
`ifdef LOGSEQ_ZERO_FLAG_EN
      chk("cyc_rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, m_zero});
`endif
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"},  32'(bus.rsp_data),      32'd0);
    chk({tag, "_rsp_err"},   {31'd0, bus.rsp_err},   32'd0);
    chk({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
`ifdef LOGSEQ_ZERO_FLAG_EN
    chk({tag, "_rsp_zero"},  {31'd0, bus.rsp_zero},  32'd0);
`endif
  endtask

  // One full transaction with literal expectations; hold = cycles of rsp_ready=0 after rsp_valid.
  task automatic do_req(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int hold, input logic [WIDTH-1:0] exp_data,
                        input logic exp_err, input logic exp_zero);
    int guard;
    int lat;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = (hold == 0);
    guard = 0;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_accept_in_time"}, {31'd0, (guard < 100)}, 32'd1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom);
        bus.req_a     = WIDTH'($urandom);
        bus.req_b     = WIDTH'($urandom);
      end
    end while (!bus.rsp_valid && lat < 100);
    chk({tag, "_latency"}, 32'(lat), exp_err ? 32'd1 : 32'(WIDTH + 1));
    chk({tag, "_data"},    32'(bus.rsp_data), 32'(exp_data));
    chk({tag, "_err"},     {31'd0, bus.rsp_err}, {31'd0, exp_err});
    chk({tag, "_busy"},    {31'd0, bus.busy}, 32'd1);
`ifdef LOGSEQ_ZERO_FLAG_EN
    chk({tag, "_zero"},    {31'd0, bus.rsp_zero}, {31'd0, exp_zero});
`else
    if (exp_zero) lat = lat + 0;
`endif
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      chk({tag, "_hold_data"},  32'(bus.rsp_data), 32'(exp_data));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_exit"},       {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_ready_gap"},  {31'd0, bus.req_ready}, 32'd0);
    chk({tag, "_err_clear"},  {31'd0, bus.rsp_err},   32'd0);
    @(negedge clk);
    chk({tag, "_ready_rise"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int guard;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_req("and",     3'd0, 8'hF0, 8'h3C, 0, 8'h30, 1'b0, 1'b0);
    do_req("xor",     3'd2, 8'hAA, 8'hFF, 0, 8'h55, 1'b0, 1'b0);
    do_req("not",     3'd3, 8'h0F, 8'h5A, 0, 8'hF0, 1'b0, 1'b0);
    do_req("rsvd",    3'd6, 8'h12, 8'h34, 0, 8'h00, 1'b1, 1'b1);
    do_req("or_hold", 3'd1, 8'h01, 8'h80, 5, 8'h81, 1'b0, 1'b0);

    // Reset pulse while the cell is on bit 4.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd1;
    bus.req_a     = 8'h55;
    bus.req_b     = 8'h0A;
    guard = 0;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst_accept_in_time", {31'd0, (guard < 100)}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    do_req("post_rst", 3'd0, 8'hFF, 8'hFF, 0, 8'hFF, 1'b0, 1'b0);

    do_req("z_and", 3'd0, 8'h0F, 8'hF0, 0, 8'h00, 1'b0, 1'b1);
    do_req("z_or",  3'd1, 8'h0F, 8'hF0, 0, 8'hFF, 1'b0, 1'b0);
    do_req("rsvd7", 3'd7, 8'hFF, 8'hFF, 2, 8'h00, 1'b1, 1'b1);

    // Randomized traffic with random backpressure; the compare process does the checking.
    repeat (3000) begin
      @(negedge clk);
      bus.req_valid = (($urandom % 3) != 0);
      bus.req_op    = ((($urandom % 5) == 0)) ? 3'(4 + ($urandom % 4)) : 3'($urandom % 4);
      bus.req_a     = WIDTH'($urandom);
      bus.req_b     = WIDTH'($urandom);
      bus.rsp_ready = (($urandom % 4) != 0);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (WIDTH + 6) @(negedge clk);
    chk("final_idle_busy", {31'd0, bus.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
